// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int MEM_DEPTH = 3101;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // True when a word address falls outside the populated memory range.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                               input int unsigned depth);
        return (addr >= ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker. On a tie the port that was not
// granted last wins; a lone requester always wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant from the current requests and the last winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the 32-bit word-addressed data memory between the
// load/store port (p0) and the loader/debug port (p1). One transaction at a
// time: IDLE accepts a request, ACCESS holds the memory pins for
// ACCESS_CYCLES cycles, RESP pulses a registered response to the winner.
// Optional feature macro: MEM_ARB_BOUNDS_CHECK_EN (out-of-range addresses are
// not forwarded to memory and are answered with resp_err).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned DEPTH         = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    output logic              p0_resp_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              p1_resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_port_q, gnt_port_d;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [1:0]        resp_err_q, resp_err_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic [1:0]        req_valid_s;
    logic [1:0]        grant_s;
    logic [1:0]        ready_s;
    logic              err_s;
    logic [DATA_W-1:0] load_data_s;

    // Requests are ignored while reset is asserted so nothing is acknowledged
    // that the reset edge would then drop.
    assign req_valid_s = {p1_valid, p0_valid} & {2{~rst}};

    mem_arb_rr u_rr (
        .valid      (req_valid_s),
        .last_grant (last_grant_q),
        .grant      (grant_s)
    );

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    assign err_s = addr_out_of_range(req_addr_q, DEPTH);
`else
    assign err_s = 1'b0;
`endif

    // Stores and rejected accesses return zero data.
    assign load_data_s = (req_write_q || err_s) ? {DATA_W{1'b0}} : mem_rdata;

    // Next-state, request latch, counter and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_port_d   = gnt_port_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        resp_valid_d = 2'b00;
        resp_err_d   = 2'b00;
        p0_rdata_d   = {DATA_W{1'b0}};
        p1_rdata_d   = {DATA_W{1'b0}};
        ready_s      = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    ready_s     = grant_s;
                    gnt_port_d  = grant_s[1];
                    req_write_d = grant_s[1] ? p1_write : p0_write;
                    req_addr_d  = grant_s[1] ? p1_addr  : p0_addr;
                    req_wdata_d = grant_s[1] ? p1_wdata : p0_wdata;
                    cnt_d       = CNT_LOAD;
                    state_d     = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = RESP;
                    if (gnt_port_q) begin
                        resp_valid_d = 2'b10;
                        resp_err_d   = {err_s, 1'b0};
                        p1_rdata_d   = load_data_s;
                    end else begin
                        resp_valid_d = 2'b01;
                        resp_err_d   = {1'b0, err_s};
                        p0_rdata_d   = load_data_s;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                last_grant_d = gnt_port_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory pins follow the latched request only while in ACCESS.
    always_comb begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if ((state_q == ACCESS) && !err_s) begin
            mem_addr  = req_addr_q;
            mem_wdata = req_wdata_q;
            mem_write = req_write_q;
            mem_read  = ~req_write_q;
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_write = 1'b0;
            mem_read  = 1'b0;
        end
    end

    // State, request and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= 1'b1;
            gnt_port_q   <= 1'b0;
            req_write_q  <= 1'b0;
            req_addr_q   <= {ADDR_W{1'b0}};
            req_wdata_q  <= {DATA_W{1'b0}};
            resp_valid_q <= 2'b00;
            resp_err_q   <= 2'b00;
            p0_rdata_q   <= {DATA_W{1'b0}};
            p1_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_port_q   <= gnt_port_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign p0_ready      = ready_s[0];
    assign p1_ready      = ready_s[1];
    assign p0_resp_valid = resp_valid_q[0];
    assign p1_resp_valid = resp_valid_q[1];
    assign p0_resp_err   = resp_err_q[0];
    assign p1_resp_err   = resp_err_q[1];
    assign p0_resp_rdata = p0_rdata_q;
    assign p1_resp_rdata = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (ACCESS_CYCLES = 1 and 3) with a
// behavioural memory each. A transaction-level reference model predicts every
// output every cycle; a directed vector table and hand-written sequences cover
// the corner cases, followed by randomized traffic.
module tb_mem_arbiter;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    localparam logic [31:0] DEPTH_W = 32'd3101;

    logic        clk;
    logic        rst;
    logic        valid      [2][2];
    logic        write      [2][2];
    logic [31:0] addr       [2][2];
    logic [31:0] wdata      [2][2];
    logic        ready      [2][2];
    logic        resp_valid [2][2];
    logic [31:0] resp_rdata [2][2];
    logic        resp_err   [2][2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic        mem_write  [2];
    logic        mem_read   [2];
    logic [31:0] mem_rdata  [2];

    logic [31:0] env_mem [2][4096];
    bit          env_wr  [2][4096];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // reference model state
    bit          m_busy  [2];
    int          m_start [2];
    int          m_last  [2];
    int          m_port  [2];
    bit          m_write [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] sh      [2][4096];
    bit          sh_wr   [2][4096];

    bit held    [2][2];
    bit rdy_seen[2][2];

    mem_arbiter #(.ACCESS_CYCLES(1)) u_dut_ac1 (
        .clk(clk), .rst(rst),
        .p0_valid(valid[0][0]), .p0_ready(ready[0][0]), .p0_write(write[0][0]),
        .p0_addr(addr[0][0]), .p0_wdata(wdata[0][0]), .p0_resp_valid(resp_valid[0][0]),
        .p0_resp_rdata(resp_rdata[0][0]), .p0_resp_err(resp_err[0][0]),
        .p1_valid(valid[0][1]), .p1_ready(ready[0][1]), .p1_write(write[0][1]),
        .p1_addr(addr[0][1]), .p1_wdata(wdata[0][1]), .p1_resp_valid(resp_valid[0][1]),
        .p1_resp_rdata(resp_rdata[0][1]), .p1_resp_err(resp_err[0][1]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_write(mem_write[0]),
        .mem_read(mem_read[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.ACCESS_CYCLES(3)) u_dut_ac3 (
        .clk(clk), .rst(rst),
        .p0_valid(valid[1][0]), .p0_ready(ready[1][0]), .p0_write(write[1][0]),
        .p0_addr(addr[1][0]), .p0_wdata(wdata[1][0]), .p0_resp_valid(resp_valid[1][0]),
        .p0_resp_rdata(resp_rdata[1][0]), .p0_resp_err(resp_err[1][0]),
        .p1_valid(valid[1][1]), .p1_ready(ready[1][1]), .p1_write(write[1][1]),
        .p1_addr(addr[1][1]), .p1_wdata(wdata[1][1]), .p1_resp_valid(resp_valid[1][1]),
        .p1_resp_rdata(resp_rdata[1][1]), .p1_resp_err(resp_err[1][1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_write(mem_write[1]),
        .mem_read(mem_read[1]), .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] init_word(input int k, input int a);
        return 32'h5A000000 ^ 32'(a) ^ (32'(k) << 20);
    endfunction

    function automatic int ac_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // behavioural memories: combinational read, write on the rising edge
    assign mem_rdata[0] = env_wr[0][mem_addr[0][11:0]] ? env_mem[0][mem_addr[0][11:0]]
                                                       : init_word(0, int'(mem_addr[0][11:0]));
    assign mem_rdata[1] = env_wr[1][mem_addr[1][11:0]] ? env_mem[1][mem_addr[1][11:0]]
                                                       : init_word(1, int'(mem_addr[1][11:0]));

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_write[k]) begin
                env_mem[k][mem_addr[k][11:0]] <= mem_wdata[k];
                env_wr[k][mem_addr[k][11:0]]  <= 1'b1;
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    function automatic logic [31:0] sh_rd(input int k, input logic [31:0] a);
        return sh_wr[k][a[11:0]] ? sh[k][a[11:0]] : init_word(k, int'(a[11:0]));
    endfunction

    // One transaction in flight per instance; its phase (cycles since accept)
    // decides what every output must show.
    task automatic model_step(input int k);
        int ac, ph, w;
        bit err, in_acc, in_resp;
        logic [31:0] exp_rd;
        ac      = ac_of(k);
        ph      = cyc - m_start[k];
        err     = BC && (m_addr[k] >= DEPTH_W);
        in_acc  = m_busy[k] && (ph >= 1) && (ph <= ac);
        in_resp = m_busy[k] && (ph == ac + 1);
        if (in_acc && m_write[k] && !err) begin
            sh[k][m_addr[k][11:0]]    = m_wdata[k];
            sh_wr[k][m_addr[k][11:0]] = 1'b1;
        end
        if (rst) begin
            m_busy[k] = 1'b0;
            m_last[k] = 1;
            return;
        end
        w = -1;
        if (!m_busy[k]) begin
            if (valid[k][0] && valid[k][1]) w = (m_last[k] == 0) ? 1 : 0;
            else if (valid[k][0])           w = 0;
            else if (valid[k][1])           w = 1;
        end
        chk($sformatf("m%0d_ready", k), {ready[k][1], ready[k][0]}, {w == 1, w == 0});
        chk($sformatf("m%0d_mem_ctl", k), {mem_write[k], mem_read[k]},
            {in_acc && !err && m_write[k], in_acc && !err && !m_write[k]});
        chk($sformatf("m%0d_mem_addr", k), mem_addr[k], (in_acc && !err) ? m_addr[k] : 32'h0);
        chk($sformatf("m%0d_resp_valid", k), {resp_valid[k][1], resp_valid[k][0]},
            {in_resp && m_port[k] == 1, in_resp && m_port[k] == 0});
        if (in_resp) begin
            exp_rd = (m_write[k] || err) ? 32'h0 : sh_rd(k, m_addr[k]);
            chk($sformatf("m%0d_rdata", k), resp_rdata[k][m_port[k]], exp_rd);
            chk($sformatf("m%0d_err", k), resp_err[k][m_port[k]], err);
            m_busy[k] = 1'b0;
            m_last[k] = m_port[k];
        end
        if (w >= 0) begin
            m_busy[k]  = 1'b1;
            m_start[k] = cyc;
            m_port[k]  = w;
            m_write[k] = write[k][w];
            m_addr[k]  = addr[k][w];
            m_wdata[k] = wdata[k][w];
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        model_step(0);
        model_step(1);
    endtask

    typedef struct {
        logic        v0, w0;
        logic [31:0] a0, d0;
        logic        v1, w1;
        logic [31:0] a1, d1;
        logic [1:0]  e_rdy, e_rv;
        logic [31:0] e_rdata;
        logic        e_mw, e_mr;
    } vec_t;

    function automatic vec_t mk(logic v0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                logic v1, logic w1, logic [31:0] a1, logic [31:0] d1,
                                logic [1:0] e_rdy, logic [1:0] e_rv, logic [31:0] e_rdata,
                                logic e_mw, logic e_mr);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_mw = e_mw; v.e_mr = e_mr;
        return v;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(3))
            0, 1:    return 32'($urandom_range(15));
            2:       return 32'(3096 + $urandom_range(9));
            default: return 32'($urandom_range(4095));
        endcase
    endfunction

    task automatic rand_step();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (held[k][p] && rdy_seen[k][p]) held[k][p] = 1'b0;
                if (held[k][p]) begin
                    if ($urandom_range(15) == 0) begin
                        held[k][p]  = 1'b0;
                        valid[k][p] = 1'b0;
                    end
                end else if ($urandom_range(1) == 1) begin
                    held[k][p]  = 1'b1;
                    valid[k][p] = 1'b1;
                    write[k][p] = 1'($urandom_range(1));
                    addr[k][p]  = pick_addr();
                    wdata[k][p] = $urandom;
                end else begin
                    valid[k][p] = 1'b0;
                end
            end
        end
    endtask

    vec_t tbl[15];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_start[k] = 0; m_last[k] = 1; m_port[k] = 0;
            m_write[k] = 1'b0; m_addr[k] = 32'h0; m_wdata[k] = 32'h0;
            for (int p = 0; p < 2; p++) begin
                valid[k][p] = 1'b0; write[k][p] = 1'b0; addr[k][p] = 32'h0; wdata[k][p] = 32'h0;
                held[k][p] = 1'b0; rdy_seen[k][p] = 1'b0;
            end
        end

        // store/load, tie after reset, loser served next, repeated tie after p0 alone
        tbl[0]  = mk(1'b1, 1'b1, 32'd5, 32'h1234ABCD, 1'b1, 1'b1, 32'd7, 32'h00000055, 2'b01, 2'b00, 32'h0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 32'd7, 32'h00000055, 2'b00, 2'b00, 32'h0, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 32'd7, 32'h00000055, 2'b00, 2'b01, 32'h0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 32'd7, 32'h00000055, 2'b10, 2'b00, 32'h0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b00, 32'h0, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b10, 32'h0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 32'd5, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b01, 2'b00, 32'h0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b00, 32'h0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b01, 32'h1234ABCD, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 32'd7, 32'h0,        1'b1, 1'b0, 32'd5, 32'h0,        2'b10, 2'b00, 32'h0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 32'd7, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b00, 32'h0, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 32'd7, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b10, 32'h1234ABCD, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 32'd7, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b01, 2'b00, 32'h0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b00, 32'h0, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0, 32'd0, 32'h0,        2'b00, 2'b01, 32'h00000055, 1'b0, 1'b0);

        // reset
        repeat (2) begin nxt(); tick(); end
        nxt(); rst = 1'b0; tick();
        chk("rst_state_ctl", {ready[0][1], ready[0][0], resp_valid[0][1], resp_valid[0][0],
                              resp_err[0][1], resp_err[0][0], mem_write[0], mem_read[0]}, 64'h0);
        chk("rst_state_data", {resp_rdata[0][0], mem_addr[0]}, 64'h0);

        // directed vector table on the single-cycle-access instance
        for (int i = 0; i < 15; i++) begin
            nxt();
            valid[0][0] = tbl[i].v0; write[0][0] = tbl[i].w0; addr[0][0] = tbl[i].a0; wdata[0][0] = tbl[i].d0;
            valid[0][1] = tbl[i].v1; write[0][1] = tbl[i].w1; addr[0][1] = tbl[i].a1; wdata[0][1] = tbl[i].d1;
            tick();
            chk($sformatf("tbl%0d_ready", i), {ready[0][1], ready[0][0]}, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_resp_valid", i), {resp_valid[0][1], resp_valid[0][0]}, tbl[i].e_rv);
            chk($sformatf("tbl%0d_mem_ctl", i), {mem_write[0], mem_read[0]}, {tbl[i].e_mw, tbl[i].e_mr});
            if (tbl[i].e_rv != 2'b00)
                chk($sformatf("tbl%0d_rdata", i), resp_rdata[0][tbl[i].e_rv[1] ? 1 : 0], tbl[i].e_rdata);
        end

        // three-cycle access on the second instance; p0 waits throughout
        nxt(); valid[1][1] = 1'b1; write[1][1] = 1'b0; addr[1][1] = 32'd9; tick();
        chk("ac3_accept", {ready[1][1], ready[1][0]}, 2'b10);
        nxt(); valid[1][1] = 1'b0; valid[1][0] = 1'b1; write[1][0] = 1'b0; addr[1][0] = 32'd3; tick();
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin nxt(); tick(); end
            chk($sformatf("ac3_pins_c%0d", c), {mem_write[1], mem_read[1], mem_addr[1]}, {2'b01, 32'd9});
            chk($sformatf("ac3_ready_c%0d", c), {ready[1][1], ready[1][0]}, 2'b00);
        end
        nxt(); tick();
        chk("ac3_resp", {resp_valid[1][1], resp_valid[1][0]}, 2'b10);
        chk("ac3_rdata", resp_rdata[1][1], init_word(1, 9));
        nxt(); tick();
        chk("ac3_next_accept", {ready[1][1], ready[1][0]}, 2'b01);
        nxt(); valid[1][0] = 1'b0; tick();
        repeat (5) begin nxt(); tick(); end

        // reset during the access cycle of a p0 store
        nxt(); valid[0][0] = 1'b1; write[0][0] = 1'b1; addr[0][0] = 32'd20; wdata[0][0] = 32'hCAFEF00D; tick();
        chk("mrst_accept", {ready[0][1], ready[0][0]}, 2'b01);
        nxt(); valid[0][0] = 1'b0; rst = 1'b1; tick();
        chk("mrst_access", mem_write[0], 1'b1);
        nxt(); rst = 1'b0; tick();
        chk("mrst_after_ctl", {resp_valid[0][1], resp_valid[0][0], resp_err[0][0],
                               mem_write[0], mem_read[0]}, 64'h0);
        chk("mrst_after_data", {resp_rdata[0][0], mem_addr[0]}, 64'h0);
        nxt(); tick();
        chk("mrst_no_resp", {resp_valid[0][1], resp_valid[0][0]}, 2'b00);
        nxt(); valid[0][0] = 1'b1; write[0][0] = 1'b0; addr[0][0] = 32'd20; tick();
        chk("mrst_reload_accept", {ready[0][1], ready[0][0]}, 2'b01);
        nxt(); valid[0][0] = 1'b0; tick();
        nxt(); tick();
        chk("mrst_reload_resp", {resp_valid[0][1], resp_valid[0][0]}, 2'b01);
        chk("mrst_reload_rdata", resp_rdata[0][0], 32'hCAFEF00D);

        // first address past the end of memory
        nxt(); valid[0][0] = 1'b1; write[0][0] = 1'b0; addr[0][0] = 32'd3101; tick();
        chk("oob_accept", {ready[0][1], ready[0][0]}, 2'b01);
        nxt(); valid[0][0] = 1'b0; tick();
        chk("oob_mem_read", mem_read[0], !BC);
        chk("oob_mem_addr", mem_addr[0], BC ? 32'd0 : 32'd3101);
        nxt(); tick();
        chk("oob_resp", {resp_valid[0][1], resp_valid[0][0]}, 2'b01);
        chk("oob_err", resp_err[0][0], BC);
        chk("oob_rdata", resp_rdata[0][0], BC ? 32'h0 : init_word(0, 3101));

        // randomized traffic on both instances against the model
        repeat (3000) begin
            nxt();
            rand_step();
            tick();
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++)
                    rdy_seen[k][p] = ready[k][p];
        end
        nxt();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                valid[k][p] = 1'b0;
        tick();
        repeat (8) begin nxt(); tick(); end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the 32-bit word-addressed data memory (3101 words). It shares the memory between the processor load/store port (port 0) and a loader/debug port (port 1) using a valid/ready request handshake and fair round-robin arbitration. It drives the memory's level-sensitive `Address`/`WriteData`/`MemWrite`/`MemRead`/`ReadData` pins, holds them stable for a configurable number of cycles, and returns a registered response to the granted port.

## Interface
- `ACCESS_CYCLES`, default 1: cycles the memory pins are held per access (≥1).
- `DEPTH`, default 3101: number of valid word addresses.
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pN_valid` in 1 (N=0,1): request present.
- `pN_ready` out 1: request accepted this cycle.
- `pN_write` in 1: 1 = store, 0 = load.
- `pN_addr` in 32: word address.
- `pN_wdata` in 32: store data.
- `pN_resp_valid` out 1: one-cycle response pulse.
- `pN_resp_rdata` out 32: load data; 0 for stores.
- `pN_resp_err` out 1: address out of range (see Configuration).
- `mem_addr` out 32, `mem_wdata` out 32, `mem_write` out 1, `mem_read` out 1: to memory.
- `mem_rdata` in 32: from memory, combinational.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `pN_valid` is high, the winner gets `pN_ready`=1 combinationally in that cycle.
  - The winner's write/addr/wdata are latched, and the state moves to ACCESS.
  - The cycle counter loads ACCESS_CYCLES-1.
- ACCESS:
  - `mem_addr`/`mem_wdata` come from the latched request, and exactly one of `mem_write`/`mem_read` is high. Both are never high together.
  - Counter decrements each cycle. When it is 0, a load captures `mem_rdata` into the response register, and the state moves to RESP.
- RESP:
  - `pN_resp_valid`=1 for the granted port only, for one cycle. Stores also pulse (write acknowledge).
  - Priority pointer updates to favour the other port. State returns to IDLE.
- Round-robin:
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - On a tie, the port ≠ `last_grant` wins. A lone requester always wins.
- Requesters must hold valid and fields stable until ready. A request withdrawn before ready is legal and ignored.
- Responses have no backpressure.
- `mem_addr`/`mem_wdata` are 0 and `mem_write`/`mem_read` are 0 outside ACCESS.

## Timing
- Accept at edge t (IDLE, valid&ready) → ACCESS on cycles t+1 … t+ACCESS_CYCLES → resp_valid on cycle t+ACCESS_CYCLES+1 → IDLE the next cycle.
- Throughput: one transaction per ACCESS_CYCLES+2 cycles. Ready is never high outside IDLE.
- Reset values:
  - State IDLE, `last_grant`=1, counter 0.
  - All `pN_ready`, `pN_resp_valid`, `pN_resp_err`, `mem_write`, `mem_read` are 0.
  - `pN_resp_rdata`, `mem_addr`, `mem_wdata` are 0.
- Reset mid-ACCESS: the transaction is dropped and no response is given. `mem_write` is low from the first cycle after the reset edge. Memory contents from an already-asserted write cycle are not rolled back.
- Simultaneous valid on both ports in IDLE: exactly one ready. The loser keeps valid and is granted at the next IDLE.

## Configuration
- `MEM_ARB_BOUNDS_CHECK_EN` defined:
  - A latched address ≥ DEPTH is not forwarded: `mem_read`/`mem_write` stay 0 for the whole ACCESS period, and `mem_addr` is driven 0.
  - The response has `resp_err`=1 and `resp_rdata`=0. Timing is unchanged.
- Undefined: `resp_err` is tied 0 and all addresses are forwarded unchanged.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, ACCESS, RESP);
  - `MEM_DEPTH`=3101;
  - `DATA_W`=32;
  - `ADDR_W`=32.
- Sub-module `mem_arb_rr`: two-way round-robin picker (valid[1:0], last_grant → grant one-hot). The remainder is the FSM and datapath.

## Test plan
- Reset, ACCESS_CYCLES=1. p0 store addr 5 data 0x1234ABCD, then p0 load addr 5 → write ack 2 cycles after accept, load `resp_rdata`=0x1234ABCD, `mem_read`/`mem_write` never both high.
- Both ports valid in the same cycle after reset → p0 granted first, p1 granted at the next IDLE (accept 3 cycles later); repeat the tie → p1 first.
- ACCESS_CYCLES=3, p1 load → mem pins stable for 3 cycles, resp_valid at accept+4, ready low throughout.
- Assert rst during ACCESS of a p0 store → no resp_valid, all outputs 0 next cycle, next request serviced normally.
- With `MEM_ARB_BOUNDS_CHECK_EN`, load addr 3101 → `resp_err`=1, `rdata`=0, `mem_read` never asserted. Without the macro → `mem_read` asserted, `resp_err`=0.
